// File: rtl/sdram_line_xfer.sv
// Cache line (4 x 32b) <-> one 8-beat x 16b SDRAM burst, one transfer in flight.
// Optional stall timeout enabled by defining SDRAM_XFER_TIMEOUT_EN.
module sdram_line_xfer #(
  parameter int ADDR_W      = 32,
  parameter int BURST_LEN   = 8,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [127:0]      req_wdata,
  output logic              resp_valid,
  output logic [127:0]      resp_rdata,
  output logic              resp_err,
  output logic [23:0]       sd_addr,
  output logic              sd_wr_req,
  output logic              sd_rd_req,
  input  logic              sd_ack,
  output logic [15:0]       sd_wdata,
  input  logic              sd_wr_beat,
  input  logic [15:0]       sd_rdata,
  input  logic              sd_rd_valid
);
  localparam int            BW   = $clog2(BURST_LEN);
  localparam logic [BW-1:0] LAST = BW'(BURST_LEN - 1);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_DATA, RD_REQ, RD_DATA, DONE} state_t;

  state_t                     state_q, state_d;
  logic                       ready_q;
  logic [23:0]                addr_q;
  logic [BURST_LEN-1:0][15:0] line_q;
  logic [BURST_LEN-1:0][15:0] rbuf_q, rbuf_d;
  logic [127:0]               rdata_q, rdata_d;
  logic [BW-1:0]              beat_q, beat_d, slot;
  logic                       accept;
  logic                       unused_ok;

  assign accept = req_valid & ready_q;
  // beat 0 travels in the most significant 16 bits of the line
  assign slot   = LAST - beat_q;

`ifdef SDRAM_XFER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic          stall_st, evt, expire;

  assign stall_st = (state_q == WR_REQ) || (state_q == RD_REQ) ||
                    (state_q == WR_DATA) || (state_q == RD_DATA);
  assign evt      = (((state_q == WR_REQ) || (state_q == RD_REQ)) && sd_ack) ||
                    ((state_q == WR_DATA) && sd_wr_beat) ||
                    ((state_q == RD_DATA) && sd_rd_valid);
  assign expire   = stall_st && !evt && (cnt_q == CW'(TIMEOUT_CYC - 1));
  assign resp_err = (state_q == DONE) & err_q;
  assign unused_ok = ^{req_addr[ADDR_W-1:25], req_addr[3:0]};
`else
  assign resp_err  = 1'b0;
  assign unused_ok = ^{req_addr[ADDR_W-1:25], req_addr[3:0], 1'(TIMEOUT_CYC)};
`endif

  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    rbuf_d  = rbuf_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = req_write ? WR_REQ : RD_REQ;
      WR_REQ:  if (sd_ack) begin state_d = WR_DATA; beat_d = '0; end
      RD_REQ:  if (sd_ack) begin state_d = RD_DATA; beat_d = '0; end
      WR_DATA: if (sd_wr_beat) begin
        if (beat_q == LAST) state_d = DONE;
        else                beat_d  = beat_q + 1'b1;
      end
      RD_DATA: if (sd_rd_valid) begin
        rbuf_d[slot] = sd_rdata;
        if (beat_q == LAST) begin
          state_d = DONE;
          rdata_d = rbuf_d;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
`ifdef SDRAM_XFER_TIMEOUT_EN
    err_d = err_q;
    if (accept) err_d = 1'b0;
    if (expire) begin
      state_d = DONE;
      err_d   = 1'b1;
    end
    cnt_d = (stall_st && !evt) ? cnt_q + 1'b1 : '0;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      addr_q  <= '0;
      line_q  <= '0;
      rbuf_q  <= '0;
      rdata_q <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == IDLE);
      rbuf_q  <= rbuf_d;
      rdata_q <= rdata_d;
      beat_q  <= beat_d;
      if (accept) begin
        addr_q <= {req_addr[24:4], 3'b000};
        line_q <= req_wdata;
      end
    end
  end

`ifdef SDRAM_XFER_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

  assign req_ready  = ready_q;
  assign resp_valid = (state_q == DONE);
  assign resp_rdata = rdata_q;
  assign sd_addr    = addr_q;
  assign sd_wr_req  = (state_q == WR_REQ);
  assign sd_rd_req  = (state_q == RD_REQ);
  assign sd_wdata   = (state_q == WR_DATA) ? line_q[slot] : 16'h0000;

endmodule

// File: tb/tb_sdram_line_xfer.sv
// Bench for sdram_line_xfer: transaction-level expectations, compared every cycle on negedge.
module tb_sdram_line_xfer;
  localparam int TO = 16;

  logic         clk = 1'b0, rst_n = 1'b0;
  logic         req_valid = 1'b0, req_write = 1'b0;
  logic [31:0]  req_addr = '0;
  logic [127:0] req_wdata = '0;
  logic         sd_ack = 1'b0, sd_wr_beat = 1'b0, sd_rd_valid = 1'b0;
  logic [15:0]  sd_rdata = '0;
  logic         req_ready, resp_valid, resp_err, sd_wr_req, sd_rd_req;
  logic [127:0] resp_rdata;
  logic [23:0]  sd_addr;
  logic [15:0]  sd_wdata;

  int n_chk = 0, n_fail = 0;

  // expected outputs for the current cycle
  logic         e_ready = 0, e_wr = 0, e_rd = 0, e_resp = 0, e_err = 0;
  logic         e_addr_chk = 1, e_wd_chk = 0;
  logic [23:0]  e_addr = '0;
  logic [15:0]  e_wd = '0;
  logic [127:0] e_rdata = '0;

  sdram_line_xfer #(.ADDR_W(32), .BURST_LEN(8), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .sd_addr(sd_addr), .sd_wr_req(sd_wr_req), .sd_rd_req(sd_rd_req), .sd_ack(sd_ack),
    .sd_wdata(sd_wdata), .sd_wr_beat(sd_wr_beat), .sd_rdata(sd_rdata),
    .sd_rd_valid(sd_rd_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("req_ready", 128'(req_ready), 128'(e_ready));
    chk("sd_wr_req", 128'(sd_wr_req), 128'(e_wr));
    chk("sd_rd_req", 128'(sd_rd_req), 128'(e_rd));
    chk("resp_valid", 128'(resp_valid), 128'(e_resp));
    chk("resp_err", 128'(resp_err), 128'(e_err));
    chk("resp_rdata", resp_rdata, e_rdata);
    if (e_addr_chk) chk("sd_addr", 128'(sd_addr), 128'(e_addr));
    if (e_wd_chk)   chk("sd_wdata", 128'(sd_wdata), 128'(e_wd));
  end

  task automatic cyc(); @(posedge clk); #1; endtask
  task automatic quiet(); sd_ack = 0; sd_wr_beat = 0; sd_rd_valid = 0; endtask
  task automatic e_busy();
    e_ready = 0; e_wr = 0; e_rd = 0; e_resp = 0; e_err = 0; e_addr_chk = 0; e_wd_chk = 0;
  endtask
  task automatic e_idle(); e_busy(); e_ready = 1; endtask
  task automatic e_zero(); e_busy(); e_addr_chk = 1; e_addr = '0; e_rdata = '0; endtask
  function automatic logic rb(input bit en); return en && ($urandom_range(0, 1) == 1); endfunction

  task automatic rst_release();
    cyc(); e_zero(); rst_n = 1;
    cyc(); e_idle();
  endtask

  task automatic stray(input int n);
    for (int k = 0; k < n; k++) begin
      cyc(); e_idle(); req_valid = 0;
      sd_ack = (k == 0) || rb(1); sd_wr_beat = (k == 0) || rb(1);
      sd_rd_valid = (k == 0) || rb(1); sd_rdata = 16'($urandom);
    end
    cyc(); e_idle(); quiet();
  endtask

  // One full line transfer; the task ends inside the completion cycle.
  task automatic xfer(input bit wr, input logic [31:0] addr, input logic [127:0] wd,
                      input int ack_wait, input int gap_max, input bit dir, input bit hold,
                      input bit noise, input int abort_at,
                      output logic [23:0] seen_addr, output logic [127:0] seen_wd);
    logic [15:0]  bt [8];
    logic [127:0] line;
    logic [23:0]  ea;
    int nb, gap;
    ea = 24'((addr >> 4) * 8);
    for (int i = 0; i < 8; i++)
      bt[i] = wr ? 16'(wd >> (16 * (7 - i)))
                 : (dir ? 16'(32'hA0A0 + 32'h0101 * i) : 16'($urandom));
    seen_addr = '0; seen_wd = '0; line = '0;
    cyc(); e_idle(); quiet();
    req_valid = 1; req_write = wr; req_addr = addr; req_wdata = wd;
    for (int k = 0; k <= ack_wait; k++) begin
      cyc(); e_busy(); e_wr = wr; e_rd = !wr; e_addr_chk = 1; e_addr = ea;
      if (k == 0) seen_addr = sd_addr;
      if (!hold) req_valid = 0;
      sd_ack = (k == ack_wait);
      sd_wr_beat = rb(noise); sd_rd_valid = rb(noise); sd_rdata = 16'($urandom);
    end
    nb = 0; gap = 0;
    while (nb < 8) begin
      cyc(); e_busy();
      if (nb == abort_at) begin
        e_zero(); quiet(); req_valid = 0;
        #1 rst_n = 0;
        #1;
        chk("rst_req_ready", 128'(req_ready), 128'(0));
        chk("rst_wr_req", 128'(sd_wr_req), 128'(0));
        chk("rst_resp_valid", 128'(resp_valid), 128'(0));
        chk("rst_sd_addr", 128'(sd_addr), 128'(0));
        chk("rst_sd_wdata", 128'(sd_wdata), 128'(0));
        chk("rst_resp_rdata", resp_rdata, 128'(0));
        return;
      end
      if (wr) begin e_wd_chk = 1; e_wd = bt[nb]; end
      sd_ack = rb(noise); sd_rdata = 16'($urandom);
      if (gap > 0) begin
        gap--;
        if (wr) begin sd_wr_beat = 0; sd_rd_valid = rb(noise); end
        else    begin sd_rd_valid = 0; sd_wr_beat = rb(noise); end
      end else begin
        if (wr) begin
          sd_wr_beat = 1; sd_rd_valid = rb(noise);
          seen_wd = (seen_wd << 16) | 128'(sd_wdata);
        end else begin
          sd_rd_valid = 1; sd_rdata = bt[nb]; sd_wr_beat = rb(noise);
          line = (line << 16) | 128'(bt[nb]);
        end
        gap = dir ? (((nb == 1) || (nb == 5)) ? 2 : 0)
                  : ((gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0);
        nb++;
      end
    end
    cyc(); e_busy(); e_resp = 1;
    if (!wr) e_rdata = line;
    quiet();
    if (noise) begin sd_rd_valid = 1; sd_wr_beat = 1; sd_rdata = 16'($urandom); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    logic [23:0]  sa;
    logic [127:0] sw;
    logic [31:0]  a;
    repeat (2) begin cyc(); e_zero(); end
    rst_release();
    stray(4);

    xfer(1, 32'h0000_1234, 128'h0001_0002_0003_0004_0005_0006_0007_0008,
         3, 0, 0, 0, 0, -1, sa, sw);
    chk("dir_wr_addr", 128'(sa), 128'h000918);
    chk("dir_wr_beats", sw, 128'h0001_0002_0003_0004_0005_0006_0007_0008);

    xfer(0, 32'h0000_1238, '0, 2, 0, 1, 0, 0, -1, sa, sw);
    chk("dir_rd_addr", 128'(sa), 128'h000918);
    chk("dir_rd_line", resp_rdata, 128'hA0A0_A1A1_A2A2_A3A3_A4A4_A5A5_A6A6_A7A7);
    chk("dir_rd_resp", 128'(resp_valid), 128'(1));

    xfer(1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 1, 0, 0, 1, 0, -1, sa, sw);
    xfer(0, $urandom, '0, 0, 2, 0, 0, 0, -1, sa, sw);
    stray(3);

    repeat (30)
      xfer(1'($urandom_range(0, 1)), $urandom, {$urandom, $urandom, $urandom, $urandom},
           int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 0,
           1'($urandom_range(0, 1)), 1, -1, sa, sw);

    a = $urandom;
    cyc(); e_idle(); quiet(); req_valid = 1; req_write = 0; req_addr = a;
`ifdef SDRAM_XFER_TIMEOUT_EN
    for (int k = 0; k < TO; k++) begin
      cyc(); e_busy(); e_rd = 1; e_addr_chk = 1; e_addr = 24'((a >> 4) * 8); req_valid = 0;
    end
    cyc(); e_busy(); e_resp = 1; e_err = 1;
    chk("to_rd_req_dropped", 128'(sd_rd_req), 128'(0));
    chk("to_resp_err", 128'(resp_err), 128'(1));
`else
    for (int k = 0; k < 40; k++) begin
      cyc(); e_busy(); e_rd = 1; e_addr_chk = 1; e_addr = 24'((a >> 4) * 8); req_valid = 0;
    end
    chk("stall_rd_req_held", 128'(sd_rd_req), 128'(1));
    cyc(); e_zero(); rst_n = 0;
    rst_release();
`endif

    xfer(1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 0, 0, 0, 0, 0, 3, sa, sw);
    rst_release();
    xfer(0, $urandom, '0, 1, 1, 0, 0, 1, -1, sa, sw);
    xfer(1, $urandom, {$urandom, $urandom, $urandom, $urandom}, 0, 1, 0, 0, 1, -1, sa, sw);
    cyc(); e_idle(); quiet();
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
